// File: rtl/dcache_pkg.sv
// Shared types and address-field widths for the direct-mapped write-through data cache.
// Offsets: 2 bits of byte offset below 2 bits of word-in-line offset.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } dcache_state_e;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 4;
  localparam int BYTE_W     = 2;
  localparam int WORD_W     = 2;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Processor strobe/ready bus plus word-serial memory bus seen by the data cache.
// slave = cache view, master = pipeline/memory (bench) view.
interface dcache_responder_if #(parameter int ADDR_W = 32);

  logic              PStrobe;
  logic              PRW;
  logic [ADDR_W-1:0] PAddress;
  logic [3:0]        PWEn;
  logic [31:0]       PDataIn;
  logic [31:0]       PDataOut;
  logic              PReady;

  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddress;
  logic [3:0]        MWEn;
  logic [31:0]       MDataOut;
  logic [31:0]       MDataIn;
  logic              MReady;

  modport slave (
    input  PStrobe, PRW, PAddress, PWEn, PDataIn,
    output PDataOut, PReady,
    output MStrobe, MRW, MAddress, MWEn, MDataOut,
    input  MDataIn, MReady
  );

  modport master (
    output PStrobe, PRW, PAddress, PWEn, PDataIn,
    input  PDataOut, PReady,
    input  MStrobe, MRW, MAddress, MWEn, MDataOut,
    output MDataIn, MReady
  );

endinterface

// File: rtl/dcache_data_array.sv
// Valid/tag/data storage: async read, synchronous byte-masked word write and tag write.
// Valid bits clear asynchronously on rst; tags and data are not reset.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [1:0]         rd_word,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [1:0]         wr_word,
  input  logic [3:0]         wr_mask,
  input  logic [31:0]        wr_data,
  input  logic               tag_wr_en,
  input  logic [INDEX_W-1:0] tag_wr_index,
  input  logic [TAG_W-1:0]   tag_wr_tag
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_word}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_wr_en) begin
      valid_q[tag_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_wr_en) tag_q[tag_wr_index] <= tag_wr_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_index, wr_word}] <= byte_merge(data_q[{wr_index, wr_word}], wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache; read hits complete with zero stall,
// misses refill 4 words (4 MReady beats + 1 cycle), stores stall until MReady then one WDONE cycle.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic             clk,
  input  logic             rst,
  dcache_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REFILL = REFILL;
  localparam logic [1:0] S_WRITE  = WRITE;
  localparam logic [1:0] S_WDONE  = WDONE;

  logic [1:0]         state_q;
  logic [1:0]         beat_q;
  logic [TAG_W-1:0]   lat_tag;
  logic [INDEX_W-1:0] lat_index;
  logic [1:0]         lat_word;
  logic [3:0]         lat_wen;
  logic [31:0]        lat_data;
  logic               lat_hit;

  logic [TAG_W-1:0]   p_tag;
  logic [INDEX_W-1:0] p_index;
  logic [1:0]         p_word;
  logic               hit;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               arr_wr_en;
  logic [1:0]         arr_wr_word;
  logic [3:0]         arr_wr_mask;
  logic [31:0]        arr_wr_data;
  logic               tag_wr_en;

  logic               unused_byte_offset;
  assign unused_byte_offset = ^bus.PAddress[BYTE_W-1:0];

  assign p_tag   = bus.PAddress[ADDR_W-1 -: TAG_W];
  assign p_index = bus.PAddress[OFFSET_W +: INDEX_W];
  assign p_word  = bus.PAddress[BYTE_W +: WORD_W];
  assign hit     = rd_valid && (rd_tag == p_tag);

  dcache_data_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (p_index),
    .rd_word      (p_word),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (arr_wr_en),
    .wr_index     (lat_index),
    .wr_word      (arr_wr_word),
    .wr_mask      (arr_wr_mask),
    .wr_data      (arr_wr_data),
    .tag_wr_en    (tag_wr_en),
    .tag_wr_index (lat_index),
    .tag_wr_tag   (lat_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      lat_tag   <= '0;
      lat_index <= '0;
      lat_word  <= 2'd0;
      lat_wen   <= 4'd0;
      lat_data  <= 32'd0;
      lat_hit   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.PStrobe) begin
            lat_tag   <= p_tag;
            lat_index <= p_index;
            lat_word  <= p_word;
            lat_wen   <= bus.PWEn;
            lat_data  <= bus.PDataIn;
            lat_hit   <= hit;
            beat_q    <= 2'd0;
            if (bus.PRW)  state_q <= S_WRITE;
            else if (!hit) state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.MReady) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (bus.MReady) state_q <= S_WDONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.MStrobe  = 1'b0;
    bus.MRW      = 1'b0;
    bus.MAddress = '0;
    bus.MWEn     = 4'd0;
    bus.MDataOut = 32'd0;
    bus.PReady   = 1'b0;
    arr_wr_en    = 1'b0;
    arr_wr_word  = lat_word;
    arr_wr_mask  = lat_wen;
    arr_wr_data  = lat_data;
    tag_wr_en    = 1'b0;
    case (state_q)
      S_IDLE: bus.PReady = !bus.PStrobe || (!bus.PRW && hit);
      S_REFILL: begin
        bus.MStrobe  = 1'b1;
        bus.MAddress = {lat_tag, lat_index, beat_q, 2'b00};
        arr_wr_en    = bus.MReady;
        arr_wr_word  = beat_q;
        arr_wr_mask  = 4'hF;
        arr_wr_data  = bus.MDataIn;
        // Line becomes valid only with its last word, so a reset mid-refill leaves it invalid.
        tag_wr_en    = bus.MReady && (beat_q == 2'd3);
      end
      S_WRITE: begin
        bus.MStrobe  = 1'b1;
        bus.MRW      = 1'b1;
        bus.MAddress = {lat_tag, lat_index, lat_word, 2'b00};
        bus.MWEn     = lat_wen;
        bus.MDataOut = lat_data;
        arr_wr_en    = bus.MReady && lat_hit;
      end
      default: bus.PReady = 1'b1;
    endcase
    if (rst) bus.PReady = 1'b0;
  end

  assign bus.PDataOut = rst ? 32'd0 : rd_data;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder against a memory-image + line-residency reference model.
module tb_dcache_responder;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_responder_if #(.ADDR_W(ADDR_W)) bus();

  dcache_responder #(.ADDR_W(ADDR_W), .INDEX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Main-memory image the bus responder serves, and the model's view of what memory should hold.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          mready_always;

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] wkey(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(wkey(a)) ? mem[wkey(a)] : seed_word(wkey(a));
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(wkey(a)) ? ref_mem[wkey(a)] : seed_word(wkey(a));
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] dat;
  } mwr_t;

  mwr_t        wr_q[$];
  logic [31:0] rd_q[$];

  always @(negedge clk) begin
    if (rst) begin
      bus.MReady  = 1'b0;
      bus.MDataIn = 32'd0;
    end else if (bus.MStrobe) begin
      bus.MReady  = mready_always || ($urandom_range(0, 2) != 0);
      bus.MDataIn = bus.MRW ? $urandom : mem_rd(bus.MAddress);
    end else begin
      // Stray MReady outside a transaction must be ignored.
      bus.MReady  = ($urandom_range(0, 7) == 0);
      bus.MDataIn = $urandom;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.MStrobe && bus.MReady) begin
      if (bus.MRW) begin
        wr_q.push_back('{addr: bus.MAddress, wen: bus.MWEn, dat: bus.MDataOut});
        mem[wkey(bus.MAddress)] = lane_merge(mem_rd(bus.MAddress), bus.MDataOut, bus.MWEn);
      end else begin
        rd_q.push_back(bus.MAddress);
      end
    end
  end

  // Residency model: which line address each index currently holds.
  logic [27:0] resident [64];
  bit          res_vld  [64];

  task automatic access(input bit rw, input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, output int cycles,
                        output logic [31:0] rdata, output bit mstb);
    bit timed_out;
    bus.PStrobe  = 1'b1;
    bus.PRW      = rw;
    bus.PAddress = addr;
    bus.PWEn     = wen;
    bus.PDataIn  = wdata;
    cycles    = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.PReady) break;
      cycles++;
      if (cycles > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    check_eq("access_timeout", timed_out, 0);
    rdata = bus.PDataOut;
    mstb  = bus.MStrobe;
    @(posedge clk);
    #1;
    bus.PStrobe  = 1'b0;
    bus.PRW      = $urandom_range(0, 1);
    bus.PAddress = $urandom;
    bus.PDataIn  = $urandom;
  endtask

  task automatic model_read(input logic [31:0] addr, input bit exact, output logic [31:0] data);
    int   cyc;
    bit   mstb;
    bit   hit;
    logic [5:0]  idx;
    logic [27:0] line;
    idx  = addr[9:4];
    line = addr[31:4];
    hit  = res_vld[idx] && (resident[idx] == line);
    rd_q.delete();
    access(1'b0, addr, 4'd0, $urandom, cyc, data, mstb);
    check_eq("rd_data", data, ref_rd(addr));
    check_eq("rd_refill_beats", rd_q.size(), hit ? 0 : 4);
    if (hit) begin
      check_eq("rd_hit_stall", cyc, 0);
      check_eq("rd_hit_mstrobe", mstb, 0);
    end else begin
      if (exact) check_eq("rd_miss_stall", cyc, 5);
      else       check_eq("rd_miss_stall_min", cyc >= 5, 1);
      if (rd_q.size() == 4)
        for (int i = 0; i < 4; i++) check_eq("rd_refill_addr", rd_q[i], {line, 4'h0} + 4 * i);
      res_vld[idx]  = 1'b1;
      resident[idx] = line;
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] wen,
                             input logic [31:0] wdata, input bit exact);
    int   cyc;
    bit   mstb;
    logic [31:0] rdata;
    wr_q.delete();
    access(1'b1, addr, wen, wdata, cyc, rdata, mstb);
    if (exact) check_eq("wr_stall", cyc, 2);
    else       check_eq("wr_stall_min", cyc >= 2, 1);
    check_eq("wr_mem_beats", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      check_eq("wr_maddr", wr_q[0].addr, wkey(addr));
      check_eq("wr_mwen", wr_q[0].wen, wen);
      check_eq("wr_mdata", wr_q[0].dat, wdata);
    end
    ref_mem[wkey(addr)] = lane_merge(ref_rd(addr), wdata, wen);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  wen_tbl [7];
    int          n;
    wen_tbl = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    rst           = 1'b1;
    mready_always = 1'b1;
    bus.PStrobe   = 1'b0;
    bus.PRW       = 1'b0;
    bus.PAddress  = 32'd0;
    bus.PWEn      = 4'd0;
    bus.PDataIn   = 32'd0;
    for (int i = 0; i < 64; i++) begin
      res_vld[i]  = 1'b0;
      resident[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 4 * i]     = 32'h11 * (i + 1);
      ref_mem[32'h100 + 4 * i] = 32'h11 * (i + 1);
    end

    #3;
    check_eq("rst_pready", bus.PReady, 0);
    check_eq("rst_pdataout", bus.PDataOut, 0);
    check_eq("rst_mstrobe", bus.MStrobe, 0);
    check_eq("rst_mrw", bus.MRW, 0);
    check_eq("rst_mwen", bus.MWEn, 0);
    check_eq("rst_maddress", bus.MAddress, 0);
    check_eq("rst_mdataout", bus.MDataOut, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then same-line hit.
    model_read(32'h0000_0104, 1'b1, d);
    check_eq("t1_data", d, 32'h22);
    model_read(32'h0000_010C, 1'b1, d);
    check_eq("t2_data", d, 32'h44);

    // Byte store hit, then read back the merged word.
    model_write(32'h0000_0108, 4'h1, 32'hAABBCCDD, 1'b1);
    model_read(32'h0000_0108, 1'b1, d);
    check_eq("t3_data", d, 32'h0000_00DD);

    // Store miss does not allocate.
    model_write(32'h0000_2000, 4'hF, 32'h1234_5678, 1'b1);
    model_read(32'h0000_2000, 1'b1, d);

    // Conflict eviction on index 0x10.
    model_read(32'h0000_0104, 1'b1, d);
    model_read(32'h0000_0504, 1'b1, d);
    model_read(32'h0000_0104, 1'b1, d);

    // Async reset in the middle of a refill of 0x904 (same index, third tag).
    rd_q.delete();
    bus.PStrobe  = 1'b1;
    bus.PRW      = 1'b0;
    bus.PAddress = 32'h0000_0904;
    n = 0;
    while (rd_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_beats_before_rst", rd_q.size(), 2);
    rst = 1'b1;
    #1;
    check_eq("t6_mstrobe", bus.MStrobe, 0);
    check_eq("t6_pready", bus.PReady, 0);
    check_eq("t6_pdataout", bus.PDataOut, 0);
    bus.PStrobe = 1'b0;
    for (int i = 0; i < 64; i++) res_vld[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_read(32'h0000_0104, 1'b1, d);
    model_read(32'h0000_0904, 1'b1, d);

    // Random mix over 4 tags x 4 indices x 4 words with random MReady gaps.
    mready_always = 1'b0;
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = ({30'd0, 2'($urandom_range(0, 3))} << 10) |
          ({26'd0, 6'($urandom_range(16, 19))} << 4) |
          ({30'd0, 2'($urandom_range(0, 3))} << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        model_write(a, wen_tbl[$urandom_range(0, 6)], $urandom, 1'b0);
      else
        model_read(a, 1'b0, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Processor-side responder for the data-memory strobe/ready handshake. The pipeline controller issues PStrobe for loads and stores, then stalls while PReady is low.
- Implements a direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
- Refills lines from main memory over a word-serial MStrobe/MReady bus.
- Sits between the MEM stage and the memory bus.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_W, 6, line index bits (64 lines).
- TAG_W, ADDR_W-INDEX_W-4, tag bits (derived; 2 bits word offset, 2 bits byte offset).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- PStrobe  in  1  access request; held with all P* inputs until PReady=1
- PRW  in  1  1=write (store), 0=read (load)
- PAddress  in  ADDR_W  byte address; bits [1:0] ignored
- PWEn  in  4  byte-lane write enables (0001/0011/1111), already lane-aligned by datapath
- PDataIn  in  32  store data
- PDataOut  out  32  load data
- PReady  out  1  access complete this cycle
- MStrobe  out  1  memory request
- MRW  out  1  memory 1=write, 0=read
- MAddress  out  ADDR_W  word-aligned memory address
- MWEn  out  4  memory byte enables
- MDataOut  out  32  memory write data
- MDataIn  in  32  memory read data
- MReady  in  1  memory beat complete (one word per MReady cycle)

Behaviour:
- Reset (async): state=IDLE, all valid bits cleared, beat counter=0. MStrobe/MRW/MWEn/MAddress/MDataOut=0. PReady=0 and PDataOut=0 while rst high.
- Decode PAddress: tag=[ADDR_W-1:INDEX_W+4], index=[INDEX_W+3:4], word=[3:2]. hit = valid[index] && tag match.
- IDLE:
  - PReady = !PStrobe || (!PRW && hit). Combinational, so a read hit completes with zero stall.
  - PDataOut = data[index][word], combinational.
  - PStrobe && !PRW && !hit -> REFILL, PReady=0; latch tag/index, beat=0.
  - PStrobe && PRW -> WRITE, PReady=0; latch address, PWEn, PDataIn, hit flag.
- REFILL:
  - MStrobe=1, MRW=0, MAddress={tag,index,beat,2'b00}.
  - Each cycle MReady=1: write MDataIn to data[index][beat], beat++.
  - On the beat-3 MReady: set valid[index], store tag, go IDLE.
  - The held request is now a hit and gets PReady=1 in the following IDLE cycle.
  - Refill latency = 4 MReady beats + 1 cycle.
- WRITE:
  - MStrobe=1, MRW=1, MAddress=latched word address, MWEn=latched PWEn, MDataOut=latched data.
  - On MReady: if the latched hit is set, byte-merge the data into data[index][word] per PWEn; go WDONE.
  - A write miss does not allocate and leaves the array untouched.
- WDONE: PReady=1 for exactly one cycle, MStrobe=0, then IDLE. The processor advances on this edge, so the store is never reissued.
- Outputs outside active states: MStrobe=0, MRW=0, MWEn=0.
- MReady while in IDLE or WDONE: ignored.
- PStrobe dropped mid-REFILL/WRITE: the transaction completes regardless (committed); there is no abort.
- MReady held high continuously: one beat per cycle, so REFILL takes 4 cycles.
- Reset mid-REFILL: the line stays invalid, with no partial valid.
- Beat counter is 2 bits and wraps to 0 after beat 3.
- Array writes are synchronous. Reads are asynchronous, so a distributed/register array is required.

Decomposition:
- Package dcache_pkg: state enum {IDLE, REFILL, WRITE, WDONE}; constants LINE_WORDS=4, OFFSET_W=4; address-field slice widths.
- Sub-module dcache_data_array:
  - Valid/tag/data storage.
  - Async read port.
  - Synchronous line-word write with 4-bit byte mask.
  - Synchronous valid/tag write.
  - Async clear of valid on rst.
- The FSM, latches and bus drive stay in dcache_responder.

Test Plan:
1. Cold read miss: PStrobe=1, PRW=0, PAddress=0x0000_0104; memory returns 0x11,0x22,0x33,0x44 at MAddress 0x100,0x104,0x108,0x10C with MReady every cycle. Required: PReady=0 for 5 cycles, then PReady=1 with PDataOut=0x22.
2. Read hit after (1): PAddress=0x0000_010C. Required: PReady=1 in the same cycle, PDataOut=0x44, MStrobe stays 0.
3. Store hit, byte: PRW=1, PAddress=0x0000_0108, PWEn=0001, PDataIn=0xAABBCCDD. Required: MStrobe=1, MRW=1, MWEn=0001, MAddress=0x108. After MReady, PReady=1 for one cycle; a subsequent read of 0x108 returns 0x000000DD.
4. Store miss: PAddress=0x0000_2000, PWEn=1111. Required: memory write issued and PReady after MReady+1. A subsequent read of 0x2000 misses and triggers a refill (no allocate).
5. Conflict eviction: read 0x0000_0104 then 0x0000_0504 (same index, different tag). Required: second access refills and overwrites; a re-read of 0x104 misses again.
6. Async reset during REFILL after beat 1: Required: MStrobe=0 immediately, state IDLE; re-request of 0x104 performs a full 4-beat refill.
